otg_hpi_sequencer: RTL and testbench

- Downstream of the OTG HPI address PIO. Consumes its 2-bit `out_port` (HPI register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS).
- Accepts single read/write commands from the NIOS-side glue.
- Drives the CY7C67200 HPI pins with a timed CS/RD/WR strobe sequence, then returns read data on a one-cycle response.
- Replaces software bit-banging of the cs/rd/wr PIOs; tri-state buffering stays at the top level.

---
 rtl/otg_hpi_pkg.sv | 36 +++
 rtl/otg_hpi_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_otg_hpi_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI access sequencer.
package otg_hpi_pkg;

    // Sequencer phases of one HPI access
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } hpi_state_t;

    // HPI register select values driven on otg_addr
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // Default phase lengths in clock cycles (50 MHz system clock)
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 2;
    localparam int DEF_RECOVER_CYC = 2;
    localparam int DEF_DW          = 16;

    // Largest of four phase lengths; sizes the shared phase counter
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/otg_hpi_sequencer.sv
// Timed CS/RD/WR strobe sequencer for single HPI register accesses.
// Every output is a flop; pin values are decoded from the next state so
// each pin changes exactly on a phase boundary.
module otg_hpi_sequencer
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int DW          = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    hpi_addr_in,
    input  logic          cmd_valid,
    input  logic          cmd_write,
    input  logic [DW-1:0] cmd_wdata,
    output logic          cmd_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [1:0]    otg_addr,
    output logic          otg_cs_n,
    output logic          otg_rd_n,
    output logic          otg_wr_n,
    output logic [DW-1:0] otg_data_out,
    output logic          otg_data_oe,
    input  logic [DW-1:0] otg_data_in
);

    localparam int MAX_CYC = max_of4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);
    localparam int CW      = $clog2(MAX_CYC) + 1;

    // Counter load values: a phase of N cycles counts N-1 down to 0
    localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_CYC - 1);

    hpi_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Command fields captured at acceptance; they drive otg_addr/otg_data_out
    logic [1:0]    addr_reg, addr_next;
    logic          write_reg, write_next;
    logic [DW-1:0] wdata_reg, wdata_next;

    // Registered control outputs
    logic          cs_n_reg, cs_n_next;
    logic          rd_n_reg, rd_n_next;
    logic          wr_n_reg, wr_n_next;
    logic          oe_reg, oe_next;
    logic          ready_reg, ready_next;
    logic          busy_reg, busy_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0] rdata_reg, rdata_next;

    // High on the clock edge that ends the last STROBE cycle
    logic          strobe_done;
    logic          in_cs_window;

    // Phase sequencing, counter reload and command capture
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        write_next  = write_reg;
        wdata_next  = wdata_reg;
        strobe_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LOAD;
                    addr_next  = hpi_addr_in;
                    write_next = cmd_write;
                    // Reads leave the last write data on the (disabled) pad driver
                    if (cmd_write) begin
                        wdata_next = cmd_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_STROBE;
                    cnt_next   = STROBE_LOAD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_reg == '0) begin
                    state_next  = ST_HOLD;
                    cnt_next    = HOLD_LOAD;
                    strobe_done = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RECOVER;
                    cnt_next   = RECOVER_LOAD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin and handshake decode from the next state
    always_comb begin
        in_cs_window   = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                         (state_next == ST_HOLD);
        cs_n_next      = ~in_cs_window;
        rd_n_next      = ~((state_next == ST_STROBE) && !write_next);
        wr_n_next      = ~((state_next == ST_STROBE) && write_next);
        oe_next        = in_cs_window && write_next;
        ready_next     = (state_next == ST_IDLE);
        busy_next      = (state_next != ST_IDLE);
        rsp_valid_next = strobe_done;
        rdata_next     = rdata_reg;
        if (strobe_done && !write_reg) begin
            rdata_next = otg_data_in;
        end
    end

    // State, counter and captured command; reset aborts any access at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            wdata_reg <= wdata_next;
        end
    end

    // Output flops; strobes and CS release asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_reg      <= 1'b1;
            rd_n_reg      <= 1'b1;
            wr_n_reg      <= 1'b1;
            oe_reg        <= 1'b0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            cs_n_reg      <= cs_n_next;
            rd_n_reg      <= rd_n_next;
            wr_n_reg      <= wr_n_next;
            oe_reg        <= oe_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign cmd_ready    = ready_reg;
    assign busy         = busy_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rdata_reg;
    assign otg_addr     = addr_reg;
    assign otg_data_out = wdata_reg;
    assign otg_cs_n     = cs_n_reg;
    assign otg_rd_n     = rd_n_reg;
    assign otg_wr_n     = wr_n_reg;
    assign otg_data_oe  = oe_reg;

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Self-checking bench for otg_hpi_sequencer: default-timing instance with a
// response scoreboard, plus a minimum-timing instance for the corner case.
module tb_otg_hpi_sequencer;

    localparam int S     = 2;
    localparam int P     = 4;
    localparam int H     = 2;
    localparam int R     = 2;
    localparam int TOTAL = S + P + H + R + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // Default-timing instance
    logic [1:0]  hpi_addr_in = 2'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_wdata = 16'h0;
    logic        cmd_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata;
    logic [1:0]  otg_addr;
    logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe;
    logic [15:0] otg_data_out;
    logic [15:0] otg_data_in = 16'h0;

    // Minimum-timing instance
    logic [1:0]  c_addr_in = 2'd0;
    logic        c_valid = 1'b0;
    logic        c_write = 1'b0;
    logic [15:0] c_wdata = 16'h0;
    logic        c_ready, c_rsp_valid, c_busy;
    logic [15:0] c_rdata;
    logic [1:0]  c_addr;
    logic        c_cs_n, c_rd_n, c_wr_n, c_oe;
    logic [15:0] c_data_out;
    logic [15:0] c_data_in = 16'h0;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_rd = 16'h0;

    always #5 clk = ~clk;

    otg_hpi_sequencer dut (
        .clk(clk), .reset(reset), .hpi_addr_in(hpi_addr_in),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .otg_addr(otg_addr), .otg_cs_n(otg_cs_n),
        .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n), .otg_data_out(otg_data_out),
        .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
    );

    otg_hpi_sequencer #(
        .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1), .DW(16)
    ) dut_min (
        .clk(clk), .reset(reset), .hpi_addr_in(c_addr_in),
        .cmd_valid(c_valid), .cmd_write(c_write), .cmd_wdata(c_wdata),
        .cmd_ready(c_ready), .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata),
        .busy(c_busy), .otg_addr(c_addr), .otg_cs_n(c_cs_n),
        .otg_rd_n(c_rd_n), .otg_wr_n(c_wr_n), .otg_data_out(c_data_out),
        .otg_data_oe(c_oe), .otg_data_in(c_data_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every response pops the value predicted at acceptance
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                logic [15:0] exp_rd;
                exp_rd = sb_q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
                $display("rsp rdata=%h exp=%h t=%0t", rsp_rdata, exp_rd, $time);
            end
        end
    end

    // Wait at negedges for cmd_ready, bounded
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 50), 32'd1);
    endtask

    // One command with per-cycle pin checks against the expected timeline
    task automatic run_txn(input logic wr, input logic [1:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd, input logic [1:0] addr_chg);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_wdata   = wd;
        hpi_addr_in = addr;
        wait_ready("accept_wait");
        @(posedge clk);
        if (!wr) last_rd = rd;
        sb_q.push_back(last_rd);
        $display("txn %s addr=%0d wdata=%h rdata=%h accepted t=%0t",
                 wr ? "WR" : "RD", addr, wd, rd, $time);
        for (int k = 1; k <= TOTAL; k++) begin
            @(negedge clk);
            cmd_valid   = 1'b0;
            otg_data_in = (!wr && k > S && k <= S + P) ? rd : 16'h0000;
            if (k == S + 2) hpi_addr_in = addr_chg;
            check("cs_n", 32'(otg_cs_n), (k <= S + P + H) ? 32'd0 : 32'd1);
            check("rd_n", 32'(otg_rd_n), (!wr && k > S && k <= S + P) ? 32'd0 : 32'd1);
            check("wr_n", 32'(otg_wr_n), (wr && k > S && k <= S + P) ? 32'd0 : 32'd1);
            check("oe", 32'(otg_data_oe), (wr && k <= S + P + H) ? 32'd1 : 32'd0);
            check("addr", 32'(otg_addr), 32'(addr));
            if (wr && k <= S + P + H) check("data_out", 32'(otg_data_out), 32'(wd));
            check("rsp_valid", 32'(rsp_valid), (k == S + P + 1) ? 32'd1 : 32'd0);
            check("busy", 32'(busy), (k < TOTAL) ? 32'd1 : 32'd0);
            check("cmd_ready", 32'(cmd_ready), (k == TOTAL) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[3];
        int n_acc;
        int hi_run;
        int min_gap;
        bit seen_low;
        bit upd;
        int n;

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_cs_n", 32'(otg_cs_n), 32'd1);
        check("rst_rd_n", 32'(otg_rd_n), 32'd1);
        check("rst_wr_n", 32'(otg_wr_n), 32'd1);
        check("rst_addr", 32'(otg_addr), 32'd0);
        check("rst_data_out", 32'(otg_data_out), 32'd0);
        check("rst_oe", 32'(otg_data_oe), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Write path, read path, address latching, write keeps rsp_rdata
        run_txn(1'b1, 2'd2, 16'h1234, 16'h0000, 2'd2);
        run_txn(1'b0, 2'd0, 16'h0000, 16'hBEEF, 2'd0);
        run_txn(1'b0, 2'd1, 16'h0000, 16'h5A5A, 2'd3);
        run_txn(1'b1, 2'd3, 16'hCAFE, 16'h0000, 2'd3);

        // Back-to-back writes with cmd_valid held
        n_acc = 0; hi_run = 0; min_gap = 1000; seen_low = 0; upd = 0;
        @(negedge clk);
        cmd_write = 1'b1; cmd_wdata = 16'h0001; hpi_addr_in = 2'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i > 0) @(negedge clk);
            if (upd) begin
                upd = 0;
                if (n_acc < 3) cmd_wdata = 16'(n_acc + 1);
                else cmd_valid = 1'b0;
            end
            if (!otg_wr_n) check("b2b_wdata", 32'(otg_data_out), 32'(n_acc));
            if (otg_cs_n) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
                seen_low = 1;
            end
            if (cmd_valid && cmd_ready) begin
                if (n_acc < 3) acc_cyc[n_acc] = i;
                $display("b2b accept %0d wdata=%h cycle=%0d", n_acc + 1, cmd_wdata, i);
                n_acc++;
                sb_q.push_back(last_rd);
                upd = 1;
            end
        end
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(TOTAL));
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(TOTAL));
        check("b2b_cs_gap", 32'(min_gap >= R), 32'd1);

        // Reset in the middle of a write strobe
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 16'hDEAD; hpi_addr_in = 2'd3;
        wait_ready("rst_accept_wait");
        @(posedge clk);
        sb_q.push_back(last_rd);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (otg_wr_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_wr_low_seen", 32'(n < 20), 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("reset asserted mid-write t=%0t", $time);
        check("abort_wr_n", 32'(otg_wr_n), 32'd1);
        check("abort_cs_n", 32'(otg_cs_n), 32'd1);
        check("abort_oe", 32'(otg_data_oe), 32'd0);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("abort_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Minimum timing read: 1 cycle per phase
        @(negedge clk);
        c_valid = 1'b1; c_write = 1'b0; c_addr_in = 2'd2;
        n = 0;
        while (!c_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("min_accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        $display("txn MIN RD addr=2 rdata=3c3c accepted t=%0t", $time);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            c_valid   = 1'b0;
            c_data_in = (k == 2) ? 16'h3C3C : 16'h0000;
            check("min_cs_n", 32'(c_cs_n), (k <= 3) ? 32'd0 : 32'd1);
            check("min_rd_n", 32'(c_rd_n), (k == 2) ? 32'd0 : 32'd1);
            check("min_wr_n", 32'(c_wr_n), 32'd1);
            check("min_oe", 32'(c_oe), 32'd0);
            check("min_addr", 32'(c_addr), 32'd2);
            check("min_rsp_valid", 32'(c_rsp_valid), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check("min_rdata", 32'(c_rdata), 32'h3C3C);
            check("min_ready", 32'(c_ready), (k == 5) ? 32'd1 : 32'd0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
